// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one synchronous-read memory port between instruction fetch (IF)
//   and load/store (LS). At most one grant per cycle, and LS has priority.
//   A starvation guard lets IF win after MAX_WAIT consecutive denied cycles.
//   Read data returns one cycle after the grant and goes to the requester
//   that issued it. An IF flush drops a fetch response still in flight.
//
//   Optional feature macro: ARB_STATS_EN. When defined, it adds saturating
//   statistic counters (stat_if_gnt, stat_ls_gnt, stat_starve).
//
// Ports
//   clk, reset                  clock; synchronous active-high reset
//   if_req/if_addr/if_flush     fetch request side
//   if_gnt/if_rvalid/if_rdata   fetch grant and response
//   ls_req/ls_we/ls_addr/ls_wdata  load/store request side
//   ls_gnt/ls_rvalid/ls_rdata   load/store grant and response (loads only)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory port
//   stat_* (ARB_STATS_EN)       grant and forced-grant counters
module mem_port_arbiter #(
  parameter int XLEN     = 32,
  parameter int AW       = 32,
  parameter int MAX_WAIT = 4,
  parameter int STAT_W   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  input  logic            if_flush,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [AW-1:0]   ls_addr,
  input  logic [XLEN-1:0] ls_wdata,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [XLEN-1:0] ls_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_if_gnt,
  output logic [STAT_W-1:0] stat_ls_gnt,
  output logic [STAT_W-1:0] stat_starve
`endif
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_e;

  owner_e        owner_q, owner_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          force_if, if_elig;

  // A flushed fetch is not eligible. It neither wins nor counts as starved.
  assign if_elig  = if_req && !if_flush;
  assign force_if = (starve_q == CW'(MAX_WAIT));

  // Both grants are held low during reset so that nothing reaches memory.
  assign ls_gnt = !reset && ls_req && !(force_if && if_elig);
  assign if_gnt = !reset && if_elig && !ls_gnt;

  assign mem_en    = if_gnt | ls_gnt;
  assign mem_we    = ls_gnt & ls_we;
  assign mem_addr  = ls_gnt ? ls_addr  : (if_gnt ? if_addr : '0);
  assign mem_wdata = ls_gnt ? ls_wdata : '0;

  // The response owner is the requester granted in the previous cycle.
  assign if_rvalid = !reset && (owner_q == OWN_IF) && !if_flush;
  assign ls_rvalid = !reset && (owner_q == OWN_LS);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign ls_rdata  = ls_rvalid ? mem_rdata : '0;

  always_comb begin
    starve_d = '0;
    if (if_elig && !if_gnt)
      starve_d = force_if ? starve_q : starve_q + CW'(1);
    owner_d = OWN_NONE;
    if (if_gnt)                owner_d = OWN_IF;
    else if (ls_gnt && !ls_we) owner_d = OWN_LS;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
      owner_q  <= OWN_NONE;
    end else begin
      starve_q <= starve_d;
      owner_q  <= owner_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] st_if_q, st_ls_q, st_sv_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_if_q <= '0;
      st_ls_q <= '0;
      st_sv_q <= '0;
    end else begin
      if (if_gnt && !(&st_if_q))             st_if_q <= st_if_q + STAT_W'(1);
      if (ls_gnt && !(&st_ls_q))             st_ls_q <= st_ls_q + STAT_W'(1);
      if (force_if && if_gnt && !(&st_sv_q)) st_sv_q <= st_sv_q + STAT_W'(1);
    end
  end

  assign stat_if_gnt = st_if_q;
  assign stat_ls_gnt = st_ls_q;
  assign stat_starve = st_sv_q;
`endif

endmodule
